// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left, shift right, parallel load.
// Built from WIDTH identical bit-slices. Each slice is a 4:1 mux feeding a
// flop with an asynchronous active-low clear. Serial-in bits come from the
// ends of d: d[0] enters at the LSB on a left shift, and d[WIDTH-1] enters
// at the MSB on a right shift.
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      logic left_in;     // bit that moves into this slice on a left shift
      logic right_in;    // bit that moves into this slice on a right shift
      logic slice_next;
      logic slice_reg;

      // LSB takes the left-shift serial input from d[0].
      if (gi == 0) begin : g_lsb
        assign left_in = d[0];
      end else begin : g_lsb_n
        assign left_in = q_reg[gi-1];
      end

      // MSB takes the right-shift serial input from d[WIDTH-1].
      if (gi == WIDTH-1) begin : g_msb
        assign right_in = d[WIDTH-1];
      end else begin : g_msb_n
        assign right_in = q_reg[gi+1];
      end

      // 4:1 mode mux; unknown ctrl values fall through to hold.
      always_comb begin
        slice_next = slice_reg;
        case (ctrl)
          MODE_HOLD: slice_next = slice_reg;
          MODE_SHL:  slice_next = left_in;
          MODE_SHR:  slice_next = right_in;
          MODE_LOAD: slice_next = d[gi];
          default:   slice_next = slice_reg;
        endcase
      end

      // Slice flop with asynchronous active-low clear.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slice_reg <= 1'b0;
        end else begin
          slice_reg <= slice_next;
        end
      end

      assign q_reg[gi] = slice_reg;
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8). Stimulus drives on
// the falling edge and pushes the value q must hold after the next rising
// edge; a monitor pops one expectation just after each rising edge.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] d;
  logic [1:0]   ctrl;
  logic [W-1:0] q;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model;   // reference register value as an integer 0..255

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .ctrl  (ctrl),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: q=%02h expected=%02h", name, act, req);
    end else begin
      $display("ok   %s: q=%02h", name, act);
    end
  endfunction

  // Reference: plain arithmetic on an integer, no bit slicing of state.
  function automatic int ref_next(input int cur, input int c, input int dv);
    int r;
    case (c)
      1:       r = (cur * 2 + (dv % 2)) % 256;
      2:       r = cur / 2 + (dv / 128) * 128;
      3:       r = dv;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, q, e.val);
      end
    end
  end

  // Model-driven cycle: expected value comes from the reference model.
  task automatic step(input logic r, input logic [1:0] c, input logic [7:0] dv, input string name);
    exp_t e;
    @(negedge clk);
    reset = r;
    ctrl  = c;
    d     = dv;
    if (!r) model = 0;
    else    model = ref_next(model, int'(c), int'(dv));
    e.name = name;
    e.val  = model[7:0];
    exp_q.push_back(e);
  endtask

  // Directed cycle: expected value is a constant given by the caller.
  task automatic step_exp(input logic r, input logic [1:0] c, input logic [7:0] dv,
                          input logic [7:0] expv, input string name);
    exp_t e;
    @(negedge clk);
    reset = r;
    ctrl  = c;
    d     = dv;
    model = int'(expv);
    e.name = name;
    e.val  = expv;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   dinc;
    logic [1:0] modes [4];
    reset = 1'b0;
    ctrl  = 2'b00;
    d     = '0;
    model = 0;
    #2;
    check("reset_initial", q, 8'h00);

    // 1. async clear mid-cycle, then held low through edges with load/FF.
    step_exp(1'b1, 2'b11, 8'h5A, 8'h5A, "load_5A");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear_mid_cycle", q, 8'h00);
    model = 0;
    ctrl  = 2'b11;
    d     = 8'hFF;
    e.name = "reset_low_edge0";
    e.val  = 8'h00;
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) step_exp(1'b0, 2'b11, 8'hFF, 8'h00, "reset_low_load_FF");

    // 2. load then hold with d changing.
    step_exp(1'b1, 2'b11, 8'hA5, 8'hA5, "load_A5");
    for (int i = 0; i < 4; i++) step_exp(1'b1, 2'b00, 8'($urandom), 8'hA5, "hold_A5");

    // 3. shift left from A5.
    step_exp(1'b1, 2'b01, 8'h01 | 8'($urandom), 8'h4B, "shl_in1");
    step_exp(1'b1, 2'b01, 8'hFE & 8'($urandom), 8'h96, "shl_in0");

    // 4. shift right from A5.
    step_exp(1'b1, 2'b11, 8'hA5, 8'hA5, "reload_A5");
    step_exp(1'b1, 2'b10, 8'h7F & 8'($urandom), 8'h52, "shr_in0");
    step_exp(1'b1, 2'b10, 8'h80 | 8'($urandom), 8'hA9, "shr_in1");

    // 5. fill with ones from the left serial input, drain with zeros from the right.
    step_exp(1'b1, 2'b11, 8'h00, 8'h00, "load_00");
    for (int i = 0; i < 8; i++)
      step_exp(1'b1, 2'b01, 8'h01, 8'((1 << (i + 1)) - 1), "fill_shl");
    for (int i = 0; i < 8; i++)
      step_exp(1'b1, 2'b10, 8'h00, 8'(255 >> (i + 1)), "drain_shr");

    // 6. incrementing d, each mode in turn, reset pulse between modes.
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11; modes[3] = 2'b00;
    dinc = 8'h30;
    for (int m = 0; m < 4; m++) begin
      step(1'b0, modes[m], 8'(dinc), "reset_pulse");
      dinc++;
      for (int k = 0; k < 6; k++) begin
        step(1'b1, modes[m], 8'(dinc), "mode_seq");
        dinc++;
      end
    end

    // Random mix with occasional reset cycles.
    for (int i = 0; i < 120; i++)
      step(($urandom_range(0, 19) != 0), 2'($urandom), 8'($urandom), "random");

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    ctrl = 2'b00;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
